// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: start/operand request and result bundle for the serial adder/subtractor.
interface serial_add_sub_if #(parameter int WIDTH = 16);
    logic             i_start;
    logic             i_sub;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_ovf;
    modport master (output i_start, i_sub, i_a, i_b, input o_busy, o_done, o_sum, o_cout, o_ovf);
    modport slave (input i_start, i_sub, i_a, i_b, output o_busy, o_done, o_sum, o_cout, o_ovf);
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: DIGIT-bit time-shared full-adder slice performing WIDTH-bit add/sub over WIDTH/DIGIT cycles.
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic            clk,
    input logic            reset,
    serial_add_sub_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_add_sub: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    logic [1:0]             r_state;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic                   r_carry;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_res;
    logic [WIDTH-1:0]       r_sum;
    logic                   r_cout;
    logic                   r_ovf;
    logic [DIGIT-1:0]       w_dsum;
    logic                   w_c;
    logic                   w_cmsb;
    logic                   w_cout;
    logic [WIDTH+DIGIT-1:0] w_cat;
    logic [WIDTH-1:0]       w_res_next;

    // Chained full-adder cells; w_cmsb ends up as the carry into the digit's top bit.
    always_comb begin
        w_c    = r_carry;
        w_cmsb = 1'b0;
        w_dsum = '0;
        for (int i = 0; i < DIGIT; i++) begin
            w_dsum[i] = r_a[i] ^ r_b[i] ^ w_c;
            w_cmsb    = w_c;
            w_c       = (r_a[i] & r_b[i]) | (w_c & (r_a[i] ^ r_b[i]));
        end
        w_cout     = w_c;
        w_cat      = {w_dsum, r_res} >> DIGIT;
        w_res_next = w_cat[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_cout;
            r_res   <= w_res_next;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == CW'(N - 1)) begin
                r_sum   <= w_res_next;
                r_cout  <= w_cout;
                r_ovf   <= w_cmsb ^ w_cout;
                r_state <= S_DONE;
            end
        end else if (bus.i_start) begin
            // Subtract as A + ~B + 1: the +1 enters through the initial carry.
            r_a     <= bus.i_a;
            r_b     <= bus.i_sub ? ~bus.i_b : bus.i_b;
            r_carry <= bus.i_sub;
            r_cnt   <= '0;
            r_state <= S_RUN;
        end else begin
            r_state <= S_IDLE;
        end
    end

    assign bus.o_busy = (r_state == S_RUN);
    assign bus.o_done = (r_state == S_DONE);
    assign bus.o_sum  = r_sum;
    assign bus.o_cout = r_cout;
    assign bus.o_ovf  = r_ovf;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: randomized and directed checks of serial_add_sub against an arithmetic reference model.
module tb_serial_add_sub;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_add_sub_if #(.WIDTH(16)) m ();
    serial_add_sub_if #(.WIDTH(16)) m1 ();
    serial_add_sub_if #(.WIDTH(16)) m16 ();

    serial_add_sub #(.WIDTH(16), .DIGIT(4))  dut   (.clk(clk), .reset(reset), .bus(m));
    serial_add_sub #(.WIDTH(16), .DIGIT(1))  dut1  (.clk(clk), .reset(reset), .bus(m1));
    serial_add_sub #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .reset(reset), .bus(m16));

    // Returns {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int r;
        int u;
        logic c;
        logic o;
        c = s ? (ua >= ub) : ((ua + ub) > 65535);
        r = s ? sa - sb : sa + sb;
        o = (r > 32767) || (r < -32768);
        u = s ? ua - ub : ua + ub;
        return {o, c, u[15:0]};
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] rs, output logic rc, output logic ro,
                         output logic rd, output int n);
        @(negedge clk);
        m.i_start = 1'b1; m.i_a = a; m.i_b = b; m.i_sub = s;
        @(negedge clk);
        m.i_start = 1'b0; m.i_a = 16'($urandom); m.i_b = 16'($urandom); m.i_sub = 1'($urandom);
        n = 0;
        while (m.o_busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        rd = m.o_done; rs = m.o_sum; rc = m.o_cout; ro = m.o_ovf;
    endtask

    task automatic test_reset();
        m.i_start = 0; m.i_sub = 0; m.i_a = 0; m.i_b = 0;
        m1.i_start = 0; m1.i_sub = 0; m1.i_a = 0; m1.i_b = 0;
        m16.i_start = 0; m16.i_sub = 0; m16.i_a = 0; m16.i_b = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({m.o_busy, m.o_done, m.o_cout, m.o_ovf, m.o_sum} !== 20'h0) begin
            failures++; $display("FAIL reset_d4 got=%h exp=0", {m.o_busy, m.o_done, m.o_cout, m.o_ovf, m.o_sum});
        end
        checks++;
        if ({m1.o_busy, m1.o_done, m1.o_cout, m1.o_ovf, m1.o_sum} !== 20'h0) begin
            failures++; $display("FAIL reset_d1 got=%h exp=0", {m1.o_busy, m1.o_done, m1.o_cout, m1.o_ovf, m1.o_sum});
        end
        checks++;
        if ({m16.o_busy, m16.o_done, m16.o_cout, m16.o_ovf, m16.o_sum} !== 20'h0) begin
            failures++; $display("FAIL reset_d16 got=%h exp=0", {m16.o_busy, m16.o_done, m16.o_cout, m16.o_ovf, m16.o_sum});
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [15:0] tb [5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
        logic        ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [17:0] te [5] = '{{2'b00, 16'h5555}, {2'b01, 16'h0000}, {2'b10, 16'h8000},
                                {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}};
        logic [15:0] rs;
        logic rc, ro, rd;
        int n;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], ts[i], rs, rc, ro, rd, n);
            checks++;
            if ({ro, rc, rs} !== te[i]) begin
                failures++; $display("FAIL directed%0d result got=%h exp=%h", i, {ro, rc, rs}, te[i]);
            end
            checks++;
            if (n !== 4 || rd !== 1'b1) begin
                failures++; $display("FAIL directed%0d timing got busy=%0d done=%b exp busy=4 done=1", i, n, rd);
            end
            @(negedge clk);
            checks++;
            if (m.o_done !== 1'b0 || m.o_sum !== te[i][15:0]) begin
                failures++; $display("FAIL directed%0d hold got done=%b sum=%h exp done=0 sum=%h", i, m.o_done, m.o_sum, te[i][15:0]);
            end
        end
    endtask

    task automatic test_mid_start();
        int n;
        @(negedge clk);
        m.i_start = 1; m.i_a = 16'h1234; m.i_b = 16'h4321; m.i_sub = 0;
        @(negedge clk);
        m.i_start = 0;
        @(negedge clk);
        m.i_start = 1; m.i_a = 16'hFFFF; m.i_b = 16'h0F0F; m.i_sub = 1;
        @(negedge clk);
        m.i_start = 0;
        n = 0;
        while (!m.o_done && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (m.o_done !== 1'b1 || {m.o_ovf, m.o_cout, m.o_sum} !== 18'h05555) begin
            failures++; $display("FAIL mid_start got done=%b res=%h exp done=1 res=05555", m.o_done, {m.o_ovf, m.o_cout, m.o_sum});
        end
        @(negedge clk);
        checks++;
        if (m.o_busy !== 1'b0) begin
            failures++; $display("FAIL mid_start_idle got busy=%b exp 0", m.o_busy);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        m.i_start = 1; m.i_a = 16'h0F0F; m.i_b = 16'h0101; m.i_sub = 0;
        @(negedge clk);
        n = 0;
        while (!m.o_done && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (m.o_done !== 1'b1 || m.o_sum !== 16'h1010 || n !== 4) begin
            failures++; $display("FAIL b2b_first got done=%b sum=%h busy=%0d exp done=1 sum=1010 busy=4", m.o_done, m.o_sum, n);
        end
        m.i_a = 16'hFFFF; m.i_b = 16'h0001; m.i_sub = 1;
        @(negedge clk);
        checks++;
        if (m.o_busy !== 1'b1 || m.o_sum !== 16'h1010) begin
            failures++; $display("FAIL b2b_nogap got busy=%b sum=%h exp busy=1 sum=1010", m.o_busy, m.o_sum);
        end
        m.i_start = 0;
        n = 0;
        while (!m.o_done && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (m.o_done !== 1'b1 || {m.o_ovf, m.o_cout, m.o_sum} !== 18'h1FFFE) begin
            failures++; $display("FAIL b2b_second got done=%b res=%h exp done=1 res=1fffe", m.o_done, {m.o_ovf, m.o_cout, m.o_sum});
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] rs;
        logic rc, ro, rd;
        int n;
        int seen;
        do_op(16'h7FFF, 16'h0001, 1'b0, rs, rc, ro, rd, n);
        @(negedge clk);
        m.i_start = 1; m.i_a = 16'h1234; m.i_b = 16'h4321; m.i_sub = 0;
        @(negedge clk);
        m.i_start = 0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({m.o_busy, m.o_done, m.o_cout, m.o_ovf, m.o_sum} !== 20'h0) begin
            failures++; $display("FAIL reset_mid got=%h exp=0", {m.o_busy, m.o_done, m.o_cout, m.o_ovf, m.o_sum});
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m.o_done || m.o_busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++; $display("FAIL reset_mid_nodone got active_cycles=%0d exp 0", seen);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, rs;
        logic s, rc, ro, rd;
        logic [17:0] e;
        int n;
        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
            if (i % 10 == 0) b = a;
            e = model(a, b, s);
            do_op(a, b, s, rs, rc, ro, rd, n);
            checks++;
            if ({ro, rc, rs} !== e || rd !== 1'b1 || n !== 4) begin
                failures++;
                $display("FAIL rnd%0d a=%h b=%h sub=%b got res=%h done=%b busy=%0d exp res=%h done=1 busy=4", i, a, b, s, {ro, rc, rs}, rd, n, e);
            end
        end
    endtask

    task automatic test_digit1();
        logic [15:0] a, b;
        logic s;
        logic [17:0] e;
        int n;
        for (int i = 0; i < 8; i++) begin
            a = (i == 0) ? 16'h1234 : 16'($urandom);
            b = (i == 0) ? 16'h4321 : 16'($urandom);
            s = (i == 0) ? 1'b0 : 1'($urandom);
            e = model(a, b, s);
            @(negedge clk);
            m1.i_start = 1; m1.i_a = a; m1.i_b = b; m1.i_sub = s;
            @(negedge clk);
            m1.i_start = 0; m1.i_a = ~a;
            n = 0;
            while (m1.o_busy && n < 100) begin
                n++;
                @(negedge clk);
            end
            checks++;
            if ({m1.o_ovf, m1.o_cout, m1.o_sum} !== e || m1.o_done !== 1'b1 || n !== 16) begin
                failures++;
                $display("FAIL digit1_%0d got res=%h done=%b busy=%0d exp res=%h done=1 busy=16", i, {m1.o_ovf, m1.o_cout, m1.o_sum}, m1.o_done, n, e);
            end
        end
    endtask

    task automatic test_digit16();
        logic [15:0] a, b;
        logic s;
        logic [17:0] e;
        int n;
        for (int i = 0; i < 8; i++) begin
            a = (i == 0) ? 16'h1234 : 16'($urandom);
            b = (i == 0) ? 16'h4321 : 16'($urandom);
            s = (i == 0) ? 1'b0 : 1'($urandom);
            e = model(a, b, s);
            @(negedge clk);
            m16.i_start = 1; m16.i_a = a; m16.i_b = b; m16.i_sub = s;
            @(negedge clk);
            m16.i_start = 0; m16.i_b = ~b;
            n = 0;
            while (m16.o_busy && n < 100) begin
                n++;
                @(negedge clk);
            end
            checks++;
            if ({m16.o_ovf, m16.o_cout, m16.o_sum} !== e || m16.o_done !== 1'b1 || n !== 1) begin
                failures++;
                $display("FAIL digit16_%0d got res=%h done=%b busy=%0d exp res=%h done=1 busy=1", i, {m16.o_ovf, m16.o_cout, m16.o_sum}, m16.o_done, n, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mid_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        test_digit1();
        test_digit16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
